// File: rtl/debug_wb_bridge_pkg.sv
// Shared types and constants for the UART-to-Wishbone debug bridge.
package debug_wb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_ADDR,
    ST_WDATA,
    ST_WB_WR,
    ST_WB_RD,
    ST_TX
  } state_e;

  localparam logic [7:0]  CMD_WRITE    = 8'h01;
  localparam logic [7:0]  CMD_READ     = 8'h02;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/debug_wb_bridge_shreg.sv
// 4-byte shift register with byte counter: collects big-endian bytes
// (address / write data) and serialises a loaded word MSB first.
module debug_wb_bridge_shreg
  import debug_wb_bridge_pkg::*;
(
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        shift_in,
  input  logic [7:0]  din,
  input  logic        shift_out,
  output logic [31:0] data,
  output logic [7:0]  byte_out,
  output logic        last
);

  logic [1:0] cnt;

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      data <= '0;
      cnt  <= '0;
    end else if (clr) begin
      cnt  <= '0;
    end else if (load) begin
      data <= load_data;
      cnt  <= '0;
    end else if (shift_in) begin
      data <= {data[23:0], din};
      cnt  <= cnt + 2'd1;
    end else if (shift_out) begin
      data <= {data[23:0], 8'h00};
      cnt  <= cnt + 2'd1;
    end
  end

  // Counter wraps to 0 on the fourth byte, so it is ready for the next word.
  assign last     = (cnt == 2'd3);
  assign byte_out = data[31:24];

endmodule

// File: rtl/debug_wb_bridge.sv
// UART byte stream to single-word Wishbone master for the debug path.
// Optional ack timeout with err_o pulse: define DEBUG_WB_BRIDGE_TIMEOUT_EN.
module debug_wb_bridge
  import debug_wb_bridge_pkg::*;
#(
  parameter int ADR_W   = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic             core_clk,
  input  logic             core_rstn,
  input  logic             debug_mode,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [3:0]       wb_sel_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack_i,
  output logic             busy
`ifdef DEBUG_WB_BRIDGE_TIMEOUT_EN
  ,
  output logic             err_o
`endif
);

  state_e state_q, state_d;

  logic [7:0]       len_q;
  logic             cmd_wr_q;
  logic [ADR_W-1:0] adr_q;

  logic        sh_clr, sh_load, sh_shift_in, sh_shift_out, sh_last;
  logic [31:0] sh_load_data, sh_data;
  logic [7:0]  sh_byte;

  logic cmd_load, len_load, len_clr, adr_load, word_done;
  logic ack_ok, tmo;

  debug_wb_bridge_shreg u_shreg (
    .core_clk  (core_clk),
    .core_rstn (core_rstn),
    .clr       (sh_clr),
    .load      (sh_load),
    .load_data (sh_load_data),
    .shift_in  (sh_shift_in),
    .din       (rx_data),
    .shift_out (sh_shift_out),
    .data      (sh_data),
    .byte_out  (sh_byte),
    .last      (sh_last)
  );

  assign ack_ok = wb_cyc_o && wb_ack_i;

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    sh_clr       = 1'b0;
    sh_load      = 1'b0;
    sh_load_data = wb_dat_i;
    sh_shift_in  = 1'b0;
    sh_shift_out = 1'b0;
    cmd_load     = 1'b0;
    len_load     = 1'b0;
    len_clr      = 1'b0;
    adr_load     = 1'b0;
    word_done    = 1'b0;
    // Leaving debug mode beats any byte or ack arriving in the same cycle.
    if (!debug_mode) begin
      state_d = ST_IDLE;
      sh_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (rx_valid && is_cmd(rx_data)) begin
          cmd_load = 1'b1;
          sh_clr   = 1'b1;
          state_d  = ST_LEN;
        end
        ST_LEN: if (rx_valid) begin
          len_load = 1'b1;
          state_d  = ST_ADDR;
        end
        ST_ADDR: if (rx_valid) begin
          sh_shift_in = 1'b1;
          if (sh_last) begin
            adr_load = 1'b1;
            if (len_q == 8'd0) state_d = ST_IDLE;
            else if (cmd_wr_q) state_d = ST_WDATA;
            else               state_d = ST_WB_RD;
          end
        end
        ST_WDATA: if (rx_valid) begin
          sh_shift_in = 1'b1;
          if (sh_last) state_d = ST_WB_WR;
        end
        ST_WB_WR: begin
          if (ack_ok) begin
            word_done = 1'b1;
            state_d   = (len_q == 8'd1) ? ST_IDLE : ST_WDATA;
          end else if (tmo) begin
            state_d = ST_IDLE;
          end
        end
        ST_WB_RD: begin
          if (ack_ok) begin
            word_done = 1'b1;
            sh_load   = 1'b1;
            state_d   = ST_TX;
          end else if (tmo) begin
            // Report the failed read as a poison word, then end the frame.
            sh_load      = 1'b1;
            sh_load_data = TIMEOUT_DATA;
            len_clr      = 1'b1;
            state_d      = ST_TX;
          end
        end
        ST_TX: if (tx_ready) begin
          sh_shift_out = 1'b1;
          if (sh_last) state_d = (len_q == 8'd0) ? ST_IDLE : ST_WB_RD;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      len_q    <= '0;
      cmd_wr_q <= 1'b0;
      adr_q    <= '0;
    end else begin
      if (cmd_load) cmd_wr_q <= (rx_data == CMD_WRITE);
      if (len_load)       len_q <= rx_data;
      else if (len_clr)   len_q <= '0;
      else if (word_done) len_q <= len_q - 8'd1;
      // Word address becomes a byte address; the final byte is still on rx_data.
      if (adr_load)       adr_q <= ADR_W'({sh_data[23:0], rx_data, 2'b00});
      else if (word_done) adr_q <= adr_q + ADR_W'(4);
    end
  end

`ifdef DEBUG_WB_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo = wb_cyc_o && !wb_ack_i && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      tmo_cnt <= '0;
      err_o   <= 1'b0;
    end else begin
      tmo_cnt <= (wb_cyc_o && state_d == state_q) ? tmo_cnt + TW'(1) : '0;
      err_o   <= debug_mode && tmo;
    end
  end
`else
  logic unused_timeout;
  assign tmo            = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign wb_cyc_o = (state_q == ST_WB_WR) || (state_q == ST_WB_RD);
  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o  = (state_q == ST_WB_WR);
  assign wb_sel_o = wb_cyc_o ? 4'hF : 4'h0;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = wb_we_o ? sh_data : 32'h0;
  assign tx_valid = (state_q == ST_TX);
  assign tx_data  = tx_valid ? sh_byte : 8'h00;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_wb_bridge.sv
// Scoreboard bench for debug_wb_bridge: random frames against a memory model.
module tb_debug_wb_bridge;
  import debug_wb_bridge_pkg::*;

  localparam int ADR_W = 32;

  logic        core_clk = 1'b0;
  logic        core_rstn, debug_mode, rx_valid, tx_valid, tx_ready;
  logic [7:0]  rx_data, tx_data;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, busy;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
`ifdef DEBUG_WB_BRIDGE_TIMEOUT_EN
  logic        err_o;
`endif

  debug_wb_bridge #(.ADR_W(ADR_W), .TIMEOUT(15)) dut (
    .core_clk(core_clk), .core_rstn(core_rstn), .debug_mode(debug_mode),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .busy(busy)
`ifdef DEBUG_WB_BRIDGE_TIMEOUT_EN
    , .err_o(err_o)
`endif
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_t;

  int          n_cmp = 0, n_err = 0, n_bus = 0, n_tx = 0;
  bus_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] wq[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] bus_mem[logic [31:0]];
  bit          resp_en = 1'b1, late_ack_req = 1'b0, tx_stall = 1'b0, stall3 = 1'b0;
  int          fixed_delay = -1;
  bit          in_cyc = 1'b0, ack_rd = 1'b0, prev_cyc = 1'b0;
  int          wn = 0, st_cnt = 0;
  bit          rdy;
  bus_t        mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  // Bus slave: random ack latency, backed by its own memory image.
  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge core_clk);
      if (wb_ack_i) begin
        wb_ack_i = 1'b0;
        if (ack_rd) chk("rd_ack_to_tx_valid", tx_valid, 1);
        ack_rd = 1'b0;
      end else if (late_ack_req) begin
        wb_ack_i     = 1'b1;
        wb_dat_i     = $urandom;
        late_ack_req = 1'b0;
      end else if (resp_en && wb_cyc_o) begin
        if (!in_cyc) begin
          in_cyc = 1'b1;
          wn     = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        end
        if (wn == 0) begin
          wb_ack_i = 1'b1;
          in_cyc   = 1'b0;
          if (wb_we_o) bus_mem[wb_adr_o] = wb_dat_o;
          else begin
            wb_dat_i = bus_mem.exists(wb_adr_o) ? bus_mem[wb_adr_o] : init_val(wb_adr_o);
            ack_rd   = 1'b1;
          end
        end else wn--;
      end else in_cyc = 1'b0;
    end
  end

  // Bus monitor: every new cycle must match the next expected access.
  always @(negedge core_clk) begin
    if (wb_cyc_o && !prev_cyc) begin
      n_bus++;
      if (exp_bus.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL bus_unexpected: cycle at adr %h, expected no cycle", wb_adr_o);
      end else begin
        mon_e = exp_bus.pop_front();
        chk("bus_adr", wb_adr_o, mon_e.adr);
        chk("bus_we", wb_we_o, mon_e.we);
        chk("bus_sel", wb_sel_o, 4'hF);
        chk("bus_stb", wb_stb_o, 1);
        if (mon_e.we) chk("bus_dat", wb_dat_o, mon_e.dat);
      end
    end
    prev_cyc = wb_cyc_o;
  end

  // UART tx sink with stalls; each accepted byte is checked against the queue.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge core_clk);
      if (tx_stall) rdy = 1'b0;
      else if (stall3) begin
        rdy    = (st_cnt == 3);
        st_cnt = (st_cnt + 1) % 4;
      end else rdy = ($urandom_range(0, 3) != 0);
      tx_ready = rdy;
      if (tx_valid && rdy) begin
        n_tx++;
        if (exp_tx.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL tx_unexpected: byte %h, expected no byte", tx_data);
        end else chk("tx_byte", tx_data, exp_tx.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 1)) @(negedge core_clk);
    @(negedge core_clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge core_clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 4000; i++) begin
      if (!busy) return;
      @(negedge core_clk);
    end
    chk(nm, busy, 0);
  endtask

  task automatic wait_cyc_low(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (!wb_cyc_o) return;
      @(negedge core_clk);
    end
    chk(nm, wb_cyc_o, 0);
  endtask

  // Issues a frame; the reference effects go into the scoreboard up front.
  task automatic send_frame(input bit we, input int len, input logic [31:0] waddr,
                            input bit full);
    logic [31:0] d[$];
    logic [31:0] a, v;
    for (int i = 0; i < len; i++) begin
      a = (waddr << 2) + 32'(4 * i);
      if (we) begin
        d.push_back(wq.pop_front());
        exp_bus.push_back('{we: 1'b1, adr: a, dat: d[i]});
        ref_mem[a] = d[i];
      end else begin
        exp_bus.push_back('{we: 1'b0, adr: a, dat: 32'h0});
        if (full) begin
          v = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
          for (int k = 3; k >= 0; k--) exp_tx.push_back(v[8*k +: 8]);
        end
      end
    end
    send_byte(we ? CMD_WRITE : CMD_READ);
    send_byte(8'(len));
    for (int k = 3; k >= 0; k--) send_byte(waddr[8*k +: 8]);
    if (we) begin
      for (int i = 0; i < len; i++) begin
        for (int k = 3; k >= 0; k--) send_byte(d[i][8*k +: 8]);
        chk("wr_stb_latency", wb_stb_o, 1);
        wait_cyc_low("wr_ack_wait");
        if (i == len - 1) chk("wr_busy_clear", busy, 0);
      end
    end
    if (full) wait_idle("frame_idle_wait");
  endtask

  int          nb, nt, cnt;
  logic [31:0] waddr;
  bit          we;
  int          len;

  initial begin
    core_rstn  = 1'b0;
    debug_mode = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = '0;
    repeat (3) @(negedge core_clk);
    chk("rst_cyc", wb_cyc_o, 0);   chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);     chk("rst_sel", wb_sel_o, 0);
    chk("rst_adr", wb_adr_o, 0);   chk("rst_dat", wb_dat_o, 0);
    chk("rst_txv", tx_valid, 0);   chk("rst_txd", tx_data, 0);
    chk("rst_busy", busy, 0);
    core_rstn = 1'b1;

    // single write, ack two cycles into the strobe
    fixed_delay = 2;
    wq.push_back(32'h12345678);
    send_frame(1'b1, 1, 32'h4, 1'b1);
    fixed_delay = -1;

    // two-word read burst with 3-cycle tx stalls
    bus_mem[32'h20] = 32'hA000_0001; ref_mem[32'h20] = 32'hA000_0001;
    bus_mem[32'h24] = 32'hAB00_0002; ref_mem[32'h24] = 32'hAB00_0002;
    stall3 = 1'b1;
    send_frame(1'b0, 2, 32'h8, 1'b1);
    stall3 = 1'b0;

    // garbage byte then a zero-length read
    nb = n_bus; nt = n_tx;
    send_byte(8'h7F);
    send_frame(1'b0, 0, 32'h0, 1'b1);
    repeat (4) @(negedge core_clk);
    chk("len0_no_bus", n_bus, nb);
    chk("len0_no_tx", n_tx, nt);
    chk("len0_idle", busy, 0);

    // abort while the read strobe is up, then a late ack
    resp_en = 1'b0;
    send_frame(1'b0, 1, 32'h10, 1'b0);
    chk("abort_pre_cyc", wb_cyc_o, 1);
    debug_mode = 1'b0;
    @(negedge core_clk);
    chk("abort_cyc", wb_cyc_o, 0);
    chk("abort_stb", wb_stb_o, 0);
    chk("abort_busy", busy, 0);
    late_ack_req = 1'b1;
    repeat (3) @(negedge core_clk);
    chk("late_ack_busy", busy, 0);
    chk("late_ack_txv", tx_valid, 0);
    debug_mode = 1'b1;
    resp_en    = 1'b1;

    // command byte coinciding with debug_mode falling is dropped
    @(negedge core_clk);
    debug_mode = 1'b0; rx_valid = 1'b1; rx_data = CMD_WRITE;
    @(negedge core_clk);
    rx_valid = 1'b0; debug_mode = 1'b1;
    chk("abort_over_rx", busy, 0);

    // fresh write after abort, read back
    wq.push_back($urandom);
    send_frame(1'b1, 1, 32'h10, 1'b1);
    send_frame(1'b0, 1, 32'h10, 1'b1);

    // asynchronous reset while holding a byte in TX
    tx_stall = 1'b1;
    send_frame(1'b0, 1, 32'h30, 1'b0);
    for (int i = 0; i < 50 && !tx_valid; i++) @(negedge core_clk);
    chk("rst_pre_tx", tx_valid, 1);
    #2 core_rstn = 1'b0;
    #1;
    chk("arst_txv", tx_valid, 0);  chk("arst_txd", tx_data, 0);
    chk("arst_busy", busy, 0);     chk("arst_cyc", wb_cyc_o, 0);
    chk("arst_adr", wb_adr_o, 0);
    @(negedge core_clk);
    core_rstn = 1'b1;
    @(negedge core_clk);
    chk("arst_release_idle", busy, 0);
    tx_stall = 1'b0;

`ifdef DEBUG_WB_BRIDGE_TIMEOUT_EN
    // unacknowledged read: 15 strobe cycles, err pulse, poison word
    resp_en = 1'b0;
    send_frame(1'b0, 1, 32'h50, 1'b0);
    for (int k = 3; k >= 0; k--) exp_tx.push_back(TIMEOUT_DATA[8*k +: 8]);
    cnt = 0;
    for (int i = 0; i < 100 && wb_cyc_o; i++) begin
      cnt++;
      @(negedge core_clk);
    end
    chk("tmo_cycles", cnt, 15);
    chk("tmo_err_pulse", err_o, 1);
    @(negedge core_clk);
    chk("tmo_err_clear", err_o, 0);
    wait_idle("tmo_idle_wait");
    resp_en = 1'b1;
`endif

    // random traffic, including address wrap at the top of the space
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 4) == 0) send_byte(8'($urandom_range(3, 255)));
      we  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) waddr = 32'hFFFF_FFFF - $urandom_range(0, 2);
      else                           waddr = $urandom_range(0, 63);
      if (we) for (int i = 0; i < len; i++) wq.push_back($urandom);
      send_frame(we, len, waddr, 1'b1);
    end

    repeat (5) @(negedge core_clk);
    chk("bus_q_drained", exp_bus.size(), 0);
    chk("tx_q_drained", exp_tx.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
